stream_join_dynamic_fifo: RTL and testbench

STREAM_JOIN_DYNAMIC_FIFO -- requirements
Module: stream_join_dynamic_fifo

---
 rtl/stream_join_dynamic_fifo.sv | 127 ++++++++++++
 tb/tb_stream_join_dynamic_fifo.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_join_dynamic_fifo.sv
// Joins N_INP independently buffered input streams into one output beat per
// selection mask; lanes not named by the mask are driven to zero.
module stream_join_dynamic_fifo #(
    parameter int N_INP      = 2,
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 2
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic [N_INP-1:0]            inp_valid_i,
    output logic [N_INP-1:0]            inp_ready_o,
    input  logic [N_INP*DATA_WIDTH-1:0] inp_data_i,
    input  logic                        sel_valid_i,
    output logic                        sel_ready_o,
    input  logic [N_INP-1:0]            sel_i,
    output logic                        oup_valid_o,
    input  logic                        oup_ready_i,
    output logic [N_INP*DATA_WIDTH-1:0] oup_data_o,
    output logic [N_INP-1:0]            oup_sel_o
);

    // Handshakes: a transfer occurs on a rising edge where valid and ready are
    // both high; a source holds valid and payload until that edge.
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic                        fire;
    logic                        out_free;
    logic                        sel_nonzero;
    logic                        sel_heads_ok;
    logic [N_INP-1:0]            avail;
    logic [N_INP*DATA_WIDTH-1:0] head_masked;

    logic                        oup_valid_q, oup_valid_d;
    logic [N_INP*DATA_WIDTH-1:0] oup_data_q, oup_data_d;
    logic [N_INP-1:0]            oup_sel_q, oup_sel_d;

    for (genvar i = 0; i < N_INP; i++) begin : g_fifo
        logic [DATA_WIDTH-1:0] mem_q [DEPTH];
        logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
        logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
        logic [CNT_W-1:0]      cnt_q, cnt_d;
        logic                  push;
        logic                  pop;

        // Ready comes only from the registered count, never from this cycle's pop.
        assign inp_ready_o[i] = (cnt_q < CNT_W'(DEPTH));
        assign avail[i]       = (cnt_q != '0);
        assign push           = inp_valid_i[i] & inp_ready_o[i];
        assign pop            = fire & sel_i[i];
        assign head_masked[i*DATA_WIDTH +: DATA_WIDTH] =
            sel_i[i] ? mem_q[rd_ptr_q] : '0;

        always_comb begin
            wr_ptr_d = wr_ptr_q;
            rd_ptr_d = rd_ptr_q;
            cnt_d    = cnt_q;
            if (push) begin
                wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
            end
            if (push && !pop) begin
                cnt_d = cnt_q + 1'b1;
            end else if (!push && pop) begin
                cnt_d = cnt_q - 1'b1;
            end
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                cnt_q    <= '0;
            end else begin
                wr_ptr_q <= wr_ptr_d;
                rd_ptr_q <= rd_ptr_d;
                cnt_q    <= cnt_d;
            end
        end

        // Storage needs no reset: the count alone decides which entries are live.
        always_ff @(posedge clk_i) begin
            if (push) begin
                mem_q[wr_ptr_q] <= inp_data_i[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign out_free     = ~oup_valid_q | oup_ready_i;
    assign sel_nonzero  = |sel_i;
    assign sel_heads_ok = &(avail | ~sel_i);
    assign fire         = sel_valid_i & sel_nonzero & out_free & sel_heads_ok;
    // An all-zero mask is retired immediately without producing a beat.
    assign sel_ready_o  = fire | (sel_valid_i & ~sel_nonzero);

    always_comb begin
        oup_valid_d = oup_valid_q;
        oup_data_d  = oup_data_q;
        oup_sel_d   = oup_sel_q;
        if (fire) begin
            oup_valid_d = 1'b1;
            oup_data_d  = head_masked;
            oup_sel_d   = sel_i;
        end else if (oup_ready_i) begin
            oup_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            oup_valid_q <= 1'b0;
            oup_data_q  <= '0;
            oup_sel_q   <= '0;
        end else begin
            oup_valid_q <= oup_valid_d;
            oup_data_q  <= oup_data_d;
            oup_sel_q   <= oup_sel_d;
        end
    end

    assign oup_valid_o = oup_valid_q;
    assign oup_data_o  = oup_data_q;
    assign oup_sel_o   = oup_sel_q;

endmodule

// File: tb/tb_stream_join_dynamic_fifo.sv
// Bench for stream_join_dynamic_fifo: directed cases on a DEPTH=2 instance and
// randomized scoreboard traffic on a DEPTH=3 instance.
module tb_stream_join_dynamic_fifo;
    localparam int N  = 2;
    localparam int DW = 8;
    localparam int EW = N + N*DW;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [N-1:0]    a_inp_valid, a_inp_ready, a_sel, a_oup_sel;
    logic [N*DW-1:0] a_inp_data, a_oup_data;
    logic            a_sel_valid, a_sel_ready, a_oup_valid, a_oup_ready;

    logic [N-1:0]    b_inp_valid, b_inp_ready, b_sel, b_oup_sel;
    logic [N*DW-1:0] b_inp_data, b_oup_data;
    logic            b_sel_valid, b_sel_ready, b_oup_valid, b_oup_ready;

    stream_join_dynamic_fifo #(.N_INP(N), .DATA_WIDTH(DW), .DEPTH(2)) dut_a (
        .clk_i(clk), .rst_ni(rst_n),
        .inp_valid_i(a_inp_valid), .inp_ready_o(a_inp_ready), .inp_data_i(a_inp_data),
        .sel_valid_i(a_sel_valid), .sel_ready_o(a_sel_ready), .sel_i(a_sel),
        .oup_valid_o(a_oup_valid), .oup_ready_i(a_oup_ready),
        .oup_data_o(a_oup_data), .oup_sel_o(a_oup_sel)
    );

    stream_join_dynamic_fifo #(.N_INP(N), .DATA_WIDTH(DW), .DEPTH(3)) dut_b (
        .clk_i(clk), .rst_ni(rst_n),
        .inp_valid_i(b_inp_valid), .inp_ready_o(b_inp_ready), .inp_data_i(b_inp_data),
        .sel_valid_i(b_sel_valid), .sel_ready_o(b_sel_ready), .sel_i(b_sel),
        .oup_valid_o(b_oup_valid), .oup_ready_i(b_oup_ready),
        .oup_data_o(b_oup_data), .oup_sel_o(b_oup_sel)
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic [EW-1:0] exp_q[$];
    logic [DW-1:0] lane_q0[$];
    logic [DW-1:0] lane_q1[$];
    logic [N-1:0]  mask_q[$];
    bit            rnd_ready;
    bit            hold_pend;
    logic [EW-1:0] hold_val;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor for dut_b: pops the scoreboard on every output handshake.
    always @(negedge clk) begin
        if (rst_n) begin
            if (hold_pend) chk("hold_stable", {b_oup_valid, b_oup_sel, b_oup_data}, {1'b1, hold_val});
            if (b_oup_valid && b_oup_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_beat: got %h required none", {b_oup_sel, b_oup_data});
                end else begin
                    chk("beat", {b_oup_sel, b_oup_data}, exp_q.pop_front());
                end
                hold_pend = 1'b0;
            end else if (b_oup_valid) begin
                hold_pend = 1'b1;
                hold_val  = {b_oup_sel, b_oup_data};
            end else begin
                hold_pend = 1'b0;
            end
        end else begin
            hold_pend = 1'b0;
        end
    end

    task automatic build_wrap();
        for (int k = 1; k <= 7; k++) begin
            lane_q0.push_back(8'(k));
            lane_q1.push_back(8'(k));
            mask_q.push_back(2'b11);
            exp_q.push_back({2'b11, 8'(k), 8'(k)});
        end
    endtask

    task automatic build_random(input int n);
        logic [N-1:0]  m;
        logic [DW-1:0] d0, d1;
        for (int i = 0; i < n; i++) begin
            m  = 2'($urandom_range(0, 3));
            d0 = 8'($urandom);
            d1 = 8'($urandom);
            mask_q.push_back(m);
            if (m[0]) lane_q0.push_back(d0);
            if (m[1]) lane_q1.push_back(d1);
            if (m != 2'b00) exp_q.push_back({m, (m[1] ? d1 : 8'h00), (m[0] ? d0 : 8'h00)});
        end
    endtask

    task automatic run_phase(input int budget);
        int cyc;
        logic [N-1:0] hs_inp;
        logic hs_sel;
        cyc = 0;
        while ((lane_q0.size() + lane_q1.size() + mask_q.size() + exp_q.size()) != 0 ||
               b_inp_valid != 2'b00 || b_sel_valid) begin
            if (cyc >= budget) begin
                n_checks++;
                n_fail++;
                $display("FAIL phase_timeout: got %0d cycles, required under %0d", cyc, budget);
                break;
            end
            if (!b_inp_valid[0] && lane_q0.size() != 0 && $urandom_range(0, 3) != 0) begin
                b_inp_valid[0]  = 1'b1;
                b_inp_data[7:0] = lane_q0.pop_front();
            end
            if (!b_inp_valid[1] && lane_q1.size() != 0 && $urandom_range(0, 3) != 0) begin
                b_inp_valid[1]   = 1'b1;
                b_inp_data[15:8] = lane_q1.pop_front();
            end
            if (!b_sel_valid && mask_q.size() != 0 && $urandom_range(0, 3) != 0) begin
                b_sel_valid = 1'b1;
                b_sel       = mask_q.pop_front();
            end
            b_oup_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            hs_inp = b_inp_valid & b_inp_ready;
            hs_sel = b_sel_valid & b_sel_ready;
            tick();
            cyc++;
            b_inp_valid = b_inp_valid & ~hs_inp;
            if (hs_sel) b_sel_valid = 1'b0;
        end
        b_oup_ready = 1'b1;
        repeat (4) tick();
    endtask

    initial begin
        #500000;
        n_checks++;
        n_fail++;
        $display("FAIL watchdog: got time limit reached, required completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        rst_n = 1'b0;
        a_inp_valid = '0; a_inp_data = '0; a_sel_valid = 1'b0; a_sel = '0; a_oup_ready = 1'b0;
        b_inp_valid = '0; b_inp_data = '0; b_sel_valid = 1'b0; b_sel = '0; b_oup_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", a_oup_valid, 1'b0);
        chk("rst_data", a_oup_data, 16'h0000);
        chk("rst_sel", a_oup_sel, 2'b00);
        chk("rst_inp_ready_a", a_inp_ready, 2'b11);
        chk("rst_inp_ready_b", b_inp_ready, 2'b11);
        chk("rst_valid_b", b_oup_valid, 1'b0);
        tick();
        rst_n = 1'b1;

        // Full join: both lanes pushed, mask 11 waiting.
        a_inp_valid = 2'b11; a_inp_data = 16'h2211; a_sel_valid = 1'b1; a_sel = 2'b11; a_oup_ready = 1'b1;
        @(negedge clk); chk("join_sel_wait", a_sel_ready, 1'b0);
        tick(); a_inp_valid = 2'b00;
        @(negedge clk); chk("join_sel_ready", a_sel_ready, 1'b1); chk("join_no_out_yet", a_oup_valid, 1'b0);
        tick(); a_sel_valid = 1'b0;
        @(negedge clk); chk("join_out", {a_oup_valid, a_oup_sel, a_oup_data}, {1'b1, 2'b11, 16'h2211});
        tick();
        @(negedge clk);
        chk("join_cleared", a_oup_valid, 1'b0);
        chk("join_data_held", {a_oup_sel, a_oup_data}, {2'b11, 16'h2211});
        chk("join_inp_ready", a_inp_ready, 2'b11);

        // Zero mask, then partial joins.
        tick(); a_inp_valid = 2'b01; a_inp_data = 16'h0011;
        tick(); a_inp_valid = 2'b00; a_sel_valid = 1'b1; a_sel = 2'b00;
        @(negedge clk); chk("zero_sel_ready", a_sel_ready, 1'b1);
        tick(); a_sel_valid = 1'b0;
        @(negedge clk); chk("zero_no_beat", a_oup_valid, 1'b0);
        tick(); a_sel_valid = 1'b1; a_sel = 2'b01;
        @(negedge clk); chk("partial_sel_ready", a_sel_ready, 1'b1);
        tick(); a_sel = 2'b10;
        @(negedge clk);
        chk("partial_out", {a_oup_valid, a_oup_sel, a_oup_data}, {1'b1, 2'b01, 16'h0011});
        chk("partial_in1_empty", a_sel_ready, 1'b0);
        tick(); a_inp_valid = 2'b10; a_inp_data = 16'h5500;
        @(negedge clk); chk("partial_wait_push", a_sel_ready, 1'b0);
        tick(); a_inp_valid = 2'b00;
        @(negedge clk); chk("partial2_sel_ready", a_sel_ready, 1'b1);
        tick(); a_sel_valid = 1'b0;
        @(negedge clk); chk("partial2_out", {a_oup_valid, a_oup_sel, a_oup_data}, {1'b1, 2'b10, 16'h5500});

        // Backpressure: output stalled while four beat pairs are offered.
        tick();
        a_oup_ready = 1'b0; a_sel_valid = 1'b1; a_sel = 2'b11; a_inp_valid = 2'b11; a_inp_data = 16'h4131;
        @(negedge clk); chk("bp_sel_wait", a_sel_ready, 1'b0);
        tick(); a_inp_data = 16'h4232;
        @(negedge clk); chk("bp_first_fire", a_sel_ready, 1'b1);
        tick(); a_inp_data = 16'h4333;
        @(negedge clk);
        chk("bp_out_first", {a_oup_valid, a_oup_data}, {1'b1, 16'h4131});
        chk("bp_sel_blocked", a_sel_ready, 1'b0);
        chk("bp_inp_ready", a_inp_ready, 2'b11);
        tick(); a_inp_valid = 2'b00;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp_full", a_inp_ready, 2'b00);
            chk("bp_hold", {a_oup_valid, a_oup_sel, a_oup_data}, {1'b1, 2'b11, 16'h4131});
            tick();
        end
        a_oup_ready = 1'b1; a_inp_valid = 2'b11; a_inp_data = 16'h4434;
        @(negedge clk);
        chk("bp_drain0", {a_oup_valid, a_oup_data}, {1'b1, 16'h4131});
        chk("bp_drain_full", a_inp_ready, 2'b00);
        tick();
        @(negedge clk);
        chk("bp_drain1", {a_oup_valid, a_oup_data}, {1'b1, 16'h4232});
        chk("bp_drain_ready", a_inp_ready, 2'b11);
        tick(); a_inp_valid = 2'b00;
        @(negedge clk); chk("bp_drain2", {a_oup_valid, a_oup_data}, {1'b1, 16'h4333});
        tick(); a_sel_valid = 1'b0;
        @(negedge clk); chk("bp_drain3", {a_oup_valid, a_oup_data}, {1'b1, 16'h4434});
        tick();
        @(negedge clk); chk("bp_idle", a_oup_valid, 1'b0);

        // Reset while both FIFOs are full and a beat is pending.
        tick();
        a_oup_ready = 1'b0; a_sel_valid = 1'b1; a_sel = 2'b11; a_inp_valid = 2'b11; a_inp_data = 16'h5161;
        repeat (3) tick();
        a_inp_valid = 2'b00;
        @(negedge clk);
        chk("rst_pre_full", a_inp_ready, 2'b00);
        chk("rst_pre_valid", a_oup_valid, 1'b1);
        tick();
        rst_n = 1'b0; a_sel_valid = 1'b0;
        #1;
        chk("rst_async_out", {a_oup_valid, a_oup_sel, a_oup_data}, 19'h0);
        chk("rst_async_ready", a_inp_ready, 2'b11);
        tick(); tick();
        rst_n = 1'b1; a_sel_valid = 1'b1; a_sel = 2'b11; a_oup_ready = 1'b1;
        @(negedge clk);
        chk("post_rst_no_stale", a_sel_ready, 1'b0);
        chk("post_rst_inp_ready", a_inp_ready, 2'b11);
        tick(); a_sel_valid = 1'b0;
        @(negedge clk); chk("post_rst_no_beat", a_oup_valid, 1'b0);

        // Scoreboard traffic on the DEPTH=3 instance.
        tick();
        rnd_ready = 1'b1;
        build_wrap();
        run_phase(2000);
        chk("wrap_drained", exp_q.size(), 0);
        build_random(60);
        run_phase(4000);
        chk("random_drained", exp_q.size(), 0);
        rnd_ready = 1'b0;
        build_random(60);
        run_phase(4000);
        chk("stream_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
